// File: rtl/alu_operand_stage.sv
// Operand-fetch / writeback stage in front of a combinational ALU.
// Reads two operands from the register file, issues them for one cycle, then writes the ALU result back.
module alu_operand_stage #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [7:0]       opcode,
    output logic             alu_valid,
    input  logic [WIDTH-1:0] rout,
    output logic             wb_done,
    output logic             illegal,
    input  logic             ld_en,
    input  logic [3:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WB    = 2'd2;
    localparam logic [7:0] OP_CMP   = 8'h0B;

    function automatic logic is_legal_op(input logic [7:0] op);
        logic ok;
        case (op)
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
            8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0E, 8'h0F, 8'h84: ok = 1'b1;
            default:                                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] r1_q, r1_d;
    logic [WIDTH-1:0] r2_q, r2_d;
    logic [7:0]       opcode_q, opcode_d;
    logic [3:0]       rdest_q, rdest_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             alu_valid_q, alu_valid_d;
    logic             instr_ready_q, instr_ready_d;
    logic             wb_done_q, wb_done_d;
    logic             illegal_q, illegal_d;
    logic             wb_en_s;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    // Sequencing: IDLE accepts, ISSUE samples rout, WB commits the result.
    always_comb begin
        state_d     = state_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        opcode_d    = opcode_q;
        rdest_d     = rdest_q;
        result_d    = result_q;
        wb_done_d   = 1'b0;
        illegal_d   = 1'b0;
        wb_en_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (is_legal_op(instr[15:8])) begin
                        r1_d     = regs_q[instr[7:4]];
                        r2_d     = regs_q[instr[3:0]];
                        opcode_d = instr[15:8];
                        rdest_d  = instr[7:4];
                        state_d  = ST_ISSUE;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                result_d  = rout;
                wb_done_d = 1'b1;
                state_d   = ST_WB;
            end
            ST_WB: begin
                wb_en_s = (opcode_q != OP_CMP);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        alu_valid_d   = (state_d == ST_ISSUE);
        instr_ready_d = (state_d == ST_IDLE);
    end

    // Register file update; the writeback is applied last so it beats a same-edge load.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (ld_en) begin
            regs_d[ld_addr] = ld_data;
        end else begin
            regs_d[ld_addr] = regs_q[ld_addr];
        end
        if (wb_en_s) begin
            regs_d[rdest_q] = result_q;
        end else begin
            regs_d[rdest_q] = regs_d[rdest_q];
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            r1_q          <= '0;
            r2_q          <= '0;
            opcode_q      <= 8'h00;
            rdest_q       <= 4'd0;
            result_q      <= '0;
            alu_valid_q   <= 1'b0;
            instr_ready_q <= 1'b1;
            wb_done_q     <= 1'b0;
            illegal_q     <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            r1_q          <= r1_d;
            r2_q          <= r2_d;
            opcode_q      <= opcode_d;
            rdest_q       <= rdest_d;
            result_q      <= result_d;
            alu_valid_q   <= alu_valid_d;
            instr_ready_q <= instr_ready_d;
            wb_done_q     <= wb_done_d;
            illegal_q     <= illegal_d;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign instr_ready = instr_ready_q;
    assign alu_valid   = alu_valid_q;
    assign r1          = r1_q;
    assign r2          = r2_q;
    assign opcode      = opcode_q;
    assign wb_done     = wb_done_q;
    assign illegal     = illegal_q;
    assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch / writeback stage sitting directly upstream of the combinational ALU.
- Accepts 16-bit two-register instructions and reads both operands from an internal register file.
- Presents r1/r2/opcode to the ALU, samples the ALU's rout, and writes it back to the destination register.
- Also provides a loader write port and a debug read port for bring-up and benches.

Parameters:
- WIDTH, 16, data/register width; must match the ALU r1/r2/rout width.
- NREGS, 16, number of general registers; index width is 4 bits.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  stage can accept an instruction this cycle.
- instr  in  16  [15:8] ALU opcode, [7:4] rdest, [3:0] rsrc.
- r1  out  WIDTH  operand A to ALU (= R[rdest]).
- r2  out  WIDTH  operand B to ALU (= R[rsrc]).
- opcode  out  8  opcode to ALU.
- alu_valid  out  1  r1/r2/opcode are valid this cycle.
- rout  in  WIDTH  ALU result (combinational from r1/r2/opcode).
- wb_done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  one-cycle pulse when an unsupported opcode is dropped.
- ld_en  in  1  loader write enable.
- ld_addr  in  4  loader register index.
- ld_data  in  WIDTH  loader write data.
- dbg_addr  in  4  debug read index.
- dbg_data  out  WIDTH  combinational R[dbg_addr].

Behaviour:
- Clock is `clock`; reset is `reset`, synchronous and active-high. Single clock domain.
- Legal opcodes: 0x01 AND, 0x02 OR, 0x03 XOR, 0x04 NOT, 0x05 ADD, 0x06 ADDU, 0x07 ADDC, 0x08 RSH, 0x09 SUB, 0x0A SUBC, 0x0B CMP, 0x0C ALSH, 0x0E MUL, 0x0F ARSH, 0x84 LSH. Every other opcode is illegal.
- FSM states: IDLE, ISSUE, WB.
  - IDLE: instr_ready=1. On instr_valid with a legal opcode, latch opcode and rdest, latch r1<=R[rdest] and r2<=R[rsrc], go to ISSUE.
  - IDLE, illegal opcode: on instr_valid, consume the instruction, pulse illegal next cycle, stay in IDLE. r1/r2/opcode are unchanged and alu_valid stays 0.
  - ISSUE: alu_valid=1 and instr_ready=0. Sample rout into a result register at the clock edge, go to WB.
  - WB: alu_valid=0 and instr_ready=0. Write result to R[rdest] unless opcode==0x0B (CMP), which writes nothing. Pulse wb_done in the same cycle, go to IDLE.
- Timing: one instruction per 3 cycles.
  - Accept edge -> alu_valid high for exactly 1 cycle -> wb_done high for exactly 1 cycle.
  - The register update is visible on dbg_data, and to the next instruction's operand read, from the cycle after WB.
- Operand reads in IDLE see all writes committed at earlier edges. There is no forwarding requirement, because WB always completes before the next accept.
- r1, r2 and opcode hold their last issued values between instructions.
- Loader port:
  - Honoured in any state.
  - If ld_en and a WB write target the same register at the same edge, the WB write wins.
  - A ld_en to a register that a pending (ISSUE) instruction has already read does not alter the latched r1/r2.
- Reset values: FSM=IDLE, all registers=0, r1=0, r2=0, opcode=0x00, alu_valid=0, wb_done=0, illegal=0. instr_ready=1 in the first cycle after reset.
- Reset asserted in ISSUE or WB aborts the instruction: no writeback and no wb_done. Reset has priority over ld_en.
- instr_valid while instr_ready=0 is ignored. The source must hold the instruction until it is accepted.
- rout is consumed only in ISSUE; its value in all other cycles is don't-care.

Test Plan:
- Reset, then load R1=1 and R2=1, then instr=0x0512 -> alu_valid with r1=1, r2=1, opcode=0x05. With bench ALU model rout=2: wb_done one cycle later and dbg_data(R1)=2.
- Load R3=0x0002 and R4=0x0003, then instr=0x0B34 (CMP) -> alu_valid once, then wb_done pulse. R3 stays 0x0002 and no register changes.
- instr=0x0D12 (illegal) -> illegal pulses one cycle after accept. alu_valid and wb_done never assert, register file unchanged, instr_ready=1 next cycle.
- Hold instr_valid high with 0x0512 back-to-back, starting from R1=1, R2=1 -> accepts every 3rd cycle and instr_ready follows 1,0,0 repeating. After 3 ADDs, R1=4.
- Assert reset during ISSUE of 0x0512 with R1=7 -> no wb_done, all registers=0, r1/r2/opcode=0, instr_ready=1 in the next cycle.
- In the WB cycle of 0x0512, drive ld_en with ld_addr=1 and ld_data=0xBEEF -> R1 holds the ALU result, not 0xBEEF.
